// File: rtl/block_lock_rx_if.sv
// rtl/block_lock_rx_if.sv - sync header stream from the rx gearbox and lock status back
interface block_lock_rx_if #(
    parameter int HEAD_W = 2
);
    logic              valid_i;
    logic [HEAD_W-1:0] head_i;
    logic              slip_o;
    logic              lock_o;
    logic              head_err_o;

    // Gearbox side: presents headers, obeys slip requests
    modport master (
        output valid_i, head_i,
        input  slip_o, lock_o, head_err_o
    );

    // Lock state machine side
    modport slave (
        input  valid_i, head_i,
        output slip_o, lock_o, head_err_o
    );
endinterface

// File: rtl/block_lock_rx.sv
// rtl/block_lock_rx.sv - 64b/66b style block lock state machine with bit slip control
module block_lock_rx #(
    parameter int HEAD_W      = 2,
    parameter int LOCK_CNT_N  = 64,
    parameter int WINDOW_N    = 1024,
    parameter int INVLD_MAX   = 16,
    parameter int SLIP_WAIT_N = 2
) (
    input  logic          clk,
    input  logic          nreset,
    block_lock_rx_if.slave bus
);

    // sh_cnt has to reach both the lock target and the window length
    localparam int CNT_MAX = (WINDOW_N > LOCK_CNT_N) ? WINDOW_N : LOCK_CNT_N;
    localparam int SH_W    = $clog2(CNT_MAX + 1);
    localparam int INV_W   = (INVLD_MAX > 1) ? $clog2(INVLD_MAX + 1) : 1;
    localparam int WAIT_W  = (SLIP_WAIT_N > 1) ? $clog2(SLIP_WAIT_N) : 1;

    localparam logic [SH_W-1:0]   LOCK_VAL   = SH_W'(LOCK_CNT_N);
    localparam logic [SH_W-1:0]   WINDOW_VAL = SH_W'(WINDOW_N);
    localparam logic [INV_W-1:0]  INVLD_VAL  = INV_W'(INVLD_MAX);
    localparam logic [WAIT_W-1:0] WAIT_LAST  = WAIT_W'(SLIP_WAIT_N - 1);

    localparam logic [HEAD_W-1:0] HEAD_DATA = {{(HEAD_W-1){1'b0}}, 1'b1};
    localparam logic [HEAD_W-1:0] HEAD_CTRL = {1'b1, {(HEAD_W-1){1'b0}}};

    typedef enum logic [1:0] {
        ST_TEST = 2'd0,
        ST_SLIP = 2'd1,
        ST_WAIT = 2'd2
    } state_t;

    state_t             r_state;
    logic [SH_W-1:0]    r_sh_cnt;
    logic [INV_W-1:0]   r_invld_cnt;
    logic [WAIT_W-1:0]  r_wait_cnt;
    logic               r_lock;
    logic               r_slip;
    logic               r_head_err;

    logic               w_accept;
    logic               w_head_ok;
    logic [SH_W-1:0]    w_sh_next;
    logic [INV_W-1:0]   w_invld_next;

    // Headers only count while testing; anything arriving during slip/realign is stale
    assign w_accept     = bus.valid_i && (r_state == ST_TEST);
    assign w_head_ok    = (bus.head_i == HEAD_DATA) || (bus.head_i == HEAD_CTRL);
    assign w_sh_next    = r_sh_cnt + SH_W'(1);
    assign w_invld_next = w_head_ok ? r_invld_cnt : (r_invld_cnt + INV_W'(1));

    assign bus.slip_o     = r_slip;
    assign bus.lock_o     = r_lock;
    assign bus.head_err_o = r_head_err;

    // Lock acquisition/monitoring, slip sequencing and registered status pulses
    always_ff @(posedge clk or negedge nreset) begin
        if (!nreset) begin
            r_state     <= ST_TEST;
            r_sh_cnt    <= '0;
            r_invld_cnt <= '0;
            r_wait_cnt  <= '0;
            r_lock      <= 1'b0;
            r_slip      <= 1'b0;
            r_head_err  <= 1'b0;
        end else begin
            r_slip     <= 1'b0;
            r_head_err <= 1'b0;
            case (r_state)
                ST_TEST: begin
                    if (w_accept) begin
                        r_head_err <= !w_head_ok;
                        if (!r_lock) begin
                            // Any bad header while hunting means the alignment is wrong
                            if (!w_head_ok) begin
                                r_state     <= ST_SLIP;
                                r_slip      <= 1'b1;
                                r_sh_cnt    <= '0;
                                r_invld_cnt <= '0;
                            end else if (w_sh_next == LOCK_VAL) begin
                                r_lock      <= 1'b1;
                                r_sh_cnt    <= '0;
                                r_invld_cnt <= '0;
                            end else begin
                                r_sh_cnt    <= w_sh_next;
                            end
                        end else begin
                            // Invalid limit is checked first so it wins on the window's last header
                            if (w_invld_next == INVLD_VAL) begin
                                r_lock      <= 1'b0;
                                r_state     <= ST_SLIP;
                                r_slip      <= 1'b1;
                                r_sh_cnt    <= '0;
                                r_invld_cnt <= '0;
                            end else if (w_sh_next == WINDOW_VAL) begin
                                r_sh_cnt    <= '0;
                                r_invld_cnt <= '0;
                            end else begin
                                r_sh_cnt    <= w_sh_next;
                                r_invld_cnt <= w_invld_next;
                            end
                        end
                    end
                end
                ST_SLIP: begin
                    r_wait_cnt <= '0;
                    if (SLIP_WAIT_N == 0) begin
                        r_state <= ST_TEST;
                    end else begin
                        r_state <= ST_WAIT;
                    end
                end
                ST_WAIT: begin
                    if (r_wait_cnt == WAIT_LAST) begin
                        r_state    <= ST_TEST;
                        r_wait_cnt <= '0;
                    end else begin
                        r_wait_cnt <= r_wait_cnt + WAIT_W'(1);
                    end
                end
                default: begin
                    r_state <= ST_TEST;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_block_lock_rx.sv
// tb/tb_block_lock_rx.sv - randomized model-checked bench for block_lock_rx
module tb_block_lock_rx;

    localparam int LOCK_N = 64;
    localparam int WIN    = 1024;
    localparam int IMAX   = 16;
    localparam int SW     = 2;

    logic clk    = 1'b0;
    logic nreset = 1'b0;
    always #5 clk = ~clk;

    block_lock_rx_if #(.HEAD_W(2)) bus ();

    block_lock_rx #(
        .HEAD_W      (2),
        .LOCK_CNT_N  (LOCK_N),
        .WINDOW_N    (WIN),
        .INVLD_MAX   (IMAX),
        .SLIP_WAIT_N (SW)
    ) dut (
        .clk    (clk),
        .nreset (nreset),
        .bus    (bus.slave)
    );

    int nchecks = 0;
    int nerrors = 0;
    bit run     = 1'b0;

    // Behavioural model state: what the receiver should be showing
    bit m_lock, m_slip, m_err;
    int m_n, m_bad, m_ignore;

    // Event tallies kept by the compare process only
    int err_pulses  = 0;
    int slip_pulses = 0;
    bit prev_slip   = 1'b0;

    task automatic chk(input string name, input logic act, input logic exp);
        nchecks++;
        if (act !== exp) begin
            nerrors++;
            $display("FAIL %s: got %0b expected %0b at %0t", name, act, exp, $time);
        end
    endtask

    task automatic chk_int(input string name, input int act, input int exp);
        nchecks++;
        if (act != exp) begin
            nerrors++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [1:0] good_h(input int i);
        return i[0] ? 2'b10 : 2'b01;
    endfunction

    function automatic logic [1:0] bad_h();
        return ($urandom & 1) ? 2'b11 : 2'b00;
    endfunction

    task automatic m_reset();
        m_lock = 0; m_slip = 0; m_err = 0;
        m_n = 0; m_bad = 0; m_ignore = 0;
    endtask

    // One clock of the reference: counts of accepted headers and invalids, a blind interval after a slip
    task automatic m_update(input bit v, input logic [1:0] h);
        bit ok;
        m_slip = 0;
        m_err  = 0;
        if (m_ignore > 0) begin
            m_ignore--;
            return;
        end
        if (!v) return;
        ok    = (h == 2'b01) || (h == 2'b10);
        m_err = !ok;
        m_n++;
        if (!ok) m_bad++;
        if (!m_lock) begin
            if (!ok) begin
                m_slip = 1; m_ignore = 1 + SW; m_n = 0; m_bad = 0;
            end else if (m_n == LOCK_N) begin
                m_lock = 1; m_n = 0; m_bad = 0;
            end
        end else begin
            if (m_bad == IMAX) begin
                m_lock = 0; m_slip = 1; m_ignore = 1 + SW; m_n = 0; m_bad = 0;
            end else if (m_n == WIN) begin
                m_n = 0; m_bad = 0;
            end
        end
    endtask

    // Drive one cycle of input, advance the model on the same edge as the DUT
    task automatic step(input bit v, input logic [1:0] h);
        bus.valid_i = v;
        bus.head_i  = h;
        @(posedge clk);
        m_update(v, h);
        #1;
    endtask

    task automatic do_reset();
        nreset = 1'b0;
        m_reset();
        repeat (2) @(posedge clk);
        #1;
        nreset = 1'b1;
    endtask

    // Asynchronous reset between edges; outputs must drop without waiting for a clock
    task automatic pulse_reset(input string tag);
        #2;
        nreset = 1'b0;
        m_reset();
        #1;
        chk({tag, "_lock_async"}, bus.lock_o, 1'b0);
        chk({tag, "_slip_async"}, bus.slip_o, 1'b0);
        chk({tag, "_err_async"},  bus.head_err_o, 1'b0);
        nreset = 1'b1;
    endtask

    task automatic send_good(input int n);
        for (int i = 0; i < n; i++) step(1'b1, good_h(i));
    endtask

    // One monitoring window with nbad invalid headers at random places; stops at the IMAX-th invalid
    task automatic run_window(input int nbad, input bit last_bad, output int seen);
        bit mark [WIN];
        int cnt;
        int p;
        for (int i = 0; i < WIN; i++) mark[i] = 1'b0;
        cnt = 0;
        if (last_bad) begin
            mark[WIN-1] = 1'b1;
            cnt = 1;
        end
        while (cnt < nbad) begin
            p = int'($urandom_range(0, WIN - 2));
            if (!mark[p]) begin
                mark[p] = 1'b1;
                cnt++;
            end
        end
        seen = 0;
        for (int i = 0; i < WIN; i++) begin
            if (mark[i]) begin
                step(1'b1, bad_h());
                seen++;
            end else begin
                step(1'b1, good_h(i));
            end
            if (seen == IMAX) break;
        end
    endtask

    // Every cycle: DUT outputs against the model, and slip never on back-to-back cycles
    always @(negedge clk) begin
        if (run) begin
            chk("slip_vs_model", bus.slip_o, m_slip);
            chk("lock_vs_model", bus.lock_o, m_lock);
            chk("err_vs_model",  bus.head_err_o, m_err);
            chk("slip_back_to_back", prev_slip && bus.slip_o, 1'b0);
            prev_slip = bus.slip_o;
            if (bus.head_err_o) err_pulses++;
            if (bus.slip_o) slip_pulses++;
        end
    end

    initial begin
        int e0, s0, seen;
        bit v;
        logic [1:0] h;
        bus.valid_i = 1'b0;
        bus.head_i  = 2'b00;
        m_reset();
        do_reset();
        run = 1'b1;

        chk("reset_lock", bus.lock_o, 1'b0);
        chk("reset_slip", bus.slip_o, 1'b0);
        chk("reset_err",  bus.head_err_o, 1'b0);

        // Clean acquisition: lock exactly one cycle after the 64th valid header
        s0 = slip_pulses;
        send_good(LOCK_N - 1);
        chk("acq_not_early", bus.lock_o, 1'b0);
        step(1'b1, 2'b10);
        chk("acq_lock", bus.lock_o, 1'b1);
        chk_int("acq_no_slip", slip_pulses - s0, 0);

        // Unlocked bad header: one-cycle slip, SLIP+WAIT headers dropped, then a fresh 64
        do_reset();
        send_good(10);
        step(1'b1, 2'b11);
        chk("slip_after_bad", bus.slip_o, 1'b1);
        chk("slip_lock_low", bus.lock_o, 1'b0);
        chk("slip_err_pulse", bus.head_err_o, 1'b1);
        step(1'b1, 2'b01);
        chk("slip_one_cycle", bus.slip_o, 1'b0);
        step(1'b1, 2'b10);
        step(1'b1, 2'b01);
        send_good(LOCK_N - 1);
        chk("relock_not_early", bus.lock_o, 1'b0);
        step(1'b1, 2'b01);
        chk("relock", bus.lock_o, 1'b1);

        // 15 invalids per window: lock held, counters must clear at the window edge
        e0 = err_pulses;
        run_window(IMAX - 1, 1'b0, seen);
        step(1'b0, 2'b00);
        chk("win1_locked", bus.lock_o, 1'b1);
        chk_int("win1_err_pulses", err_pulses - e0, IMAX - 1);
        e0 = err_pulses;
        run_window(IMAX - 1, 1'b1, seen);
        step(1'b0, 2'b00);
        chk("win2_locked", bus.lock_o, 1'b1);
        chk_int("win2_err_pulses", err_pulses - e0, IMAX - 1);
        run_window(IMAX - 1, 1'b0, seen);
        chk("win3_locked", bus.lock_o, 1'b1);

        // 16th invalid inside the window loses lock
        e0 = err_pulses;
        run_window(IMAX, 1'b0, seen);
        chk_int("loss_seen", seen, IMAX);
        chk("loss_lock", bus.lock_o, 1'b0);
        chk("loss_slip", bus.slip_o, 1'b1);
        step(1'b0, 2'b00);
        chk_int("loss_err_pulses", err_pulses - e0, IMAX);
        step(1'b0, 2'b00);
        step(1'b0, 2'b00);
        send_good(LOCK_N);
        chk("relock2", bus.lock_o, 1'b1);

        // 16th invalid is header 1024: loss beats window clear
        e0 = err_pulses;
        run_window(IMAX, 1'b1, seen);
        chk("prio_lock", bus.lock_o, 1'b0);
        chk("prio_slip", bus.slip_o, 1'b1);
        step(1'b0, 2'b00);
        chk_int("prio_err_pulses", err_pulses - e0, IMAX);

        // Acquisition with valid_i gaps of 1-3 cycles
        do_reset();
        for (int i = 0; i < LOCK_N; i++) begin
            step(1'b1, good_h(i));
            if (i == LOCK_N - 2) chk("gap_not_early", bus.lock_o, 1'b0);
            if (i < LOCK_N - 1) begin
                repeat ($urandom_range(1, 3)) step(1'b0, 2'($urandom));
            end
        end
        chk("gap_lock", bus.lock_o, 1'b1);

        // Async reset while locked, during SLIP and during WAIT
        send_good(7);
        pulse_reset("locked");
        step(1'b1, 2'b00);
        chk("pre_slip_a", bus.slip_o, 1'b1);
        pulse_reset("in_slip");
        step(1'b1, 2'b11);
        step(1'b1, 2'b01);
        pulse_reset("in_wait");
        send_good(LOCK_N - 1);
        chk("post_rst_not_early", bus.lock_o, 1'b0);
        step(1'b1, 2'b10);
        chk("post_rst_lock", bus.lock_o, 1'b1);

        // Random traffic alternating clean and noisy phases
        do_reset();
        for (int ph = 0; ph < 6; ph++) begin
            for (int i = 0; i < 500; i++) begin
                v = ($urandom_range(0, 4) != 0);
                if ($urandom_range(0, (ph[0] ? 19 : 199)) == 0) h = bad_h();
                else h = good_h(int'($urandom));
                step(v, h);
            end
        end

        $display("Simulation finished: %0d checks, %0d errors", nchecks, nerrors);
        $finish;
    end

endmodule
